// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and state encoding, common to the receive
// demultiplexer and the transmit-side slot sequencer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear to 0, load to 1 on frame start, advance on beats,
// with a combinational flag marking the last slot of the frame.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              wrap_c
);

  logic [SLOT_W-1:0] slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SLOT_W'(1);
    end else if (en) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot   = slot_q;
  assign wrap_c = (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM receive demultiplexer: frames a serial stream on its sync marker,
// reassembles each frame into a parallel word and tracks lock/framing errors.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 en,
  input  logic                 sync,
  output logic [NUM_SLOTS-1:0] q,
  output logic                 q_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 err
);

  state_e               state_d, state_q;
  logic [NUM_SLOTS-1:0] shift_d, shift_q;
  logic [NUM_SLOTS-1:0] q_d, q_q;
  logic                 q_valid_d, q_valid_q;
  logic                 err_d, err_q;
  logic                 locked_d, locked_q;
  logic                 ctr_en, ctr_load1, ctr_clr;
  logic [SLOT_W-1:0]    slot_cur;
  logic                 last_slot_c;

  tdm_slot_ctr u_slot_ctr (
    .clk    (clk),
    .rst    (rst),
    .en     (ctr_en),
    .load1  (ctr_load1),
    .clr    (ctr_clr),
    .slot   (slot_cur),
    .wrap_c (last_slot_c)
  );

  // Frame start always clears the shift register so stale bits never reach q.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    err_d     = 1'b0;
    ctr_en    = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shift_d   = NUM_SLOTS'(din);
            ctr_load1 = 1'b1;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            err_d     = (slot_cur != '0);
            shift_d   = NUM_SLOTS'(din);
            ctr_load1 = 1'b1;
          end else if (slot_cur == '0) begin
            if (SYNC_CHECK) begin
              err_d   = 1'b1;
              ctr_clr = 1'b1;
              state_d = HUNT;
            end else begin
              shift_d   = NUM_SLOTS'(din);
              ctr_load1 = 1'b1;
            end
          end else if (last_slot_c) begin
            q_d       = {din, shift_q[NUM_SLOTS-2:0]};
            q_valid_d = 1'b1;
            ctr_en    = 1'b1;
          end else begin
            shift_d[slot_cur] = din;
            ctr_en            = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      shift_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign slot    = slot_cur;
  assign locked  = locked_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: two instances (sync checked / not checked) driven in
// lockstep and compared each cycle against a queue-based frame model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst, din, en, sync;
  logic [7:0] q0, q1;
  logic       qv0, qv1, lk0, lk1, er0, er1;
  logic [2:0] sl0, sl1;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  always #5 clk = ~clk;

  tdm_demux8 #(.SYNC_CHECK(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .q(q0), .q_valid(qv0), .slot(sl0), .locked(lk0), .err(er0)
  );

  tdm_demux8 #(.SYNC_CHECK(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .q(q1), .q_valid(qv1), .slot(sl1), .locked(lk1), .err(er1)
  );

  // Model: index 0 has sync checking off, index 1 on. The frame in progress is
  // a queue of received bits; its length is the slot the next beat lands in.
  bit         fr [2][$];
  bit         m_lk [2];
  logic [7:0] m_q  [2];
  bit         m_qv [2];
  bit         m_er [2];

  function automatic void mstep(int m, bit r, bit e, bit s, bit d);
    m_qv[m] = 1'b0;
    m_er[m] = 1'b0;
    if (r) begin
      m_lk[m] = 1'b0;
      m_q[m]  = 8'h00;
      fr[m].delete();
    end else if (e) begin
      if (!m_lk[m]) begin
        if (s) begin
          fr[m].delete();
          fr[m].push_back(d);
          m_lk[m] = 1'b1;
        end
      end else if (s) begin
        if (fr[m].size() != 0) m_er[m] = 1'b1;
        fr[m].delete();
        fr[m].push_back(d);
      end else if (fr[m].size() == 0) begin
        if (m == 1) begin
          m_er[m] = 1'b1;
          m_lk[m] = 1'b0;
        end else begin
          fr[m].push_back(d);
        end
      end else begin
        fr[m].push_back(d);
        if (fr[m].size() == 8) begin
          for (int k = 0; k < 8; k++) m_q[m][k] = fr[m][k];
          m_qv[m] = 1'b1;
          fr[m].delete();
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cycle_no, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit s, input bit d);
    rst = r; en = e; sync = s; din = d;
    for (int m = 0; m < 2; m++) mstep(m, r, e, s, d);
    @(posedge clk);
    #1;
    cycle_no++;
    chk("sc0_q",      q0,        m_q[0]);
    chk("sc0_qvalid", 8'(qv0),   8'(m_qv[0]));
    chk("sc0_slot",   8'(sl0),   8'(fr[0].size()));
    chk("sc0_locked", 8'(lk0),   8'(m_lk[0]));
    chk("sc0_err",    8'(er0),   8'(m_er[0]));
    chk("sc1_q",      q1,        m_q[1]);
    chk("sc1_qvalid", 8'(qv1),   8'(m_qv[1]));
    chk("sc1_slot",   8'(sl1),   8'(fr[1].size()));
    chk("sc1_locked", 8'(lk1),   8'(m_lk[1]));
    chk("sc1_err",    8'(er1),   8'(m_er[1]));
  endtask

  task automatic send_frame(input logic [7:0] v, input bit sync_first, input int max_gap);
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && max_gap > 0) begin
        int g;
        g = int'($urandom_range(max_gap, 1));
        for (int i = 0; i < g; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b1, (k == 0) && sync_first, v[k]);
    end
  endtask

  typedef struct {
    bit         rst, en, sync, din;
    logic [7:0] q;
    bit         qv;
    logic [2:0] slot;
    bit         lk, er;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Hand-derived clean frame 8'hAD applied to both instances.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd6, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hAD, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hAD, 1'b0, 3'd0, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].sync, tbl[i].din);
      chk("tbl_q0",    q0,      tbl[i].q);
      chk("tbl_q1",    q1,      tbl[i].q);
      chk("tbl_qv1",   8'(qv1), 8'(tbl[i].qv));
      chk("tbl_slot1", 8'(sl1), 8'(tbl[i].slot));
      chk("tbl_lk1",   8'(lk1), 8'(tbl[i].lk));
      chk("tbl_err1",  8'(er1), 8'(tbl[i].er));
    end

    // Same frame with idle gaps between beats.
    send_frame(8'hAD, 1'b1, 3);
    chk("gap_frame_q", q1, 8'hAD);

    // Early sync at slot 4, then the sync beat starts a clean 8'h3C frame.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, k == 0, 1'b1);
    send_frame(8'h3C, 1'b1, 0);
    chk("early_sync_q", q1, 8'h3C);

    // Good frame, then a slot-0 beat without sync, then relock.
    send_frame(8'h5A, 1'b1, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("miss_sync_err",    8'(er1), 8'h01);
    chk("miss_sync_locked", 8'(lk1), 8'h00);
    send_frame(8'h96, 1'b1, 0);

    // Back-to-back frames with sync only on the first.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 0);
    chk("b2b_q_01", q0, 8'h01);
    send_frame(8'h80, 1'b0, 0);
    chk("b2b_q_80", q0, 8'h80);
    send_frame(8'hFF, 1'b0, 0);
    chk("b2b_q_ff", q0, 8'hFF);

    // Reset mid-frame at slot 5.
    send_frame(8'hC3, 1'b1, 0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, k == 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_q", q1, 8'h00);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic, biased so frames usually stay aligned.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, s;
      r = ($urandom_range(199, 0) == 0);
      e = ($urandom_range(3, 0) != 0);
      if ($urandom_range(9, 0) == 0) s = 1'($urandom);
      else s = (fr[1].size() == 0) && ($urandom_range(3, 0) != 0);
      cyc(r, e, s, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
